// File: rtl/camera_pixel_packer.sv
// Camera capture front end: samples a parallel sensor bus, truncates and decimates pixels,
// packs them into words with in-band sop/eol marks, and buffers them in a show-ahead FIFO.
module camera_pixel_packer #(
  parameter int unsigned PIX_W        = 12,
  parameter int unsigned OUT_PIX_W    = 8,
  parameter int unsigned PIX_PER_WORD = 4,
  parameter int unsigned FIFO_DEPTH   = 16,
  localparam int unsigned WORD_W      = OUT_PIX_W * PIX_PER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        skip,
  input  logic              frame_valid,
  input  logic              line_valid,
  input  logic [PIX_W-1:0]  data,
  output logic [WORD_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       frame_count,
  output logic              overflow,
  input  logic              clear_overflow,
  output logic              busy
);

  localparam int unsigned LaneW  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW = WORD_W + 2;

  typedef enum logic [1:0] {StIdle, StArmed, StCapture} state_e;

  // Input stage is deliberately not reset: after a reset mid-frame the edge detectors must keep
  // seeing the true sensor level, otherwise the remainder of that frame looks like a new frame.
  logic                 fv_q, lv_q, fv_prev_q, lv_prev_q;
  logic [OUT_PIX_W-1:0] pix_q;

  always_ff @(posedge clk) begin
    fv_q      <= frame_valid;
    lv_q      <= line_valid;
    fv_prev_q <= fv_q;
    lv_prev_q <= lv_q;
    pix_q     <= data[PIX_W-1 -: OUT_PIX_W];
  end

  if (PIX_W > OUT_PIX_W) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^data[PIX_W-OUT_PIX_W-1:0];
  end

  state_e              state_q;
  logic [15:0]         frame_count_q;
  logic [1:0]          skip_q, decim_q, decim_eff;
  logic [WORD_W-1:0]   asm_q, asm_ins, pend_q, cm_word;
  logic [LaneW-1:0]    asm_cnt_q;
  logic                pend_valid_q, sop_flag_q;
  logic                fv_rise, fv_fall, lv_rise, lv_fall;
  logic                capturing, keep, asm_full, line_end;
  logic                cm_valid, cm_eol;
  logic                wr_q;
  logic [EntryW-1:0]   wr_entry_q;
  logic                overflow_q;

  logic [EntryW-1:0]   mem [FIFO_DEPTH];
  logic [AddrW:0]      wr_ptr_q, rd_ptr_q;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [EntryW-1:0]   head;

  assign fv_rise   = fv_q & ~fv_prev_q;
  assign fv_fall   = ~fv_q & fv_prev_q;
  assign lv_rise   = lv_q & ~lv_prev_q;
  assign lv_fall   = ~lv_q & lv_prev_q;
  assign capturing = (state_q == StCapture);
  assign line_end  = capturing & lv_fall;
  assign decim_eff = lv_rise ? 2'd0 : decim_q;
  assign keep      = capturing & fv_q & lv_q & (decim_eff == 2'd0);
  assign asm_full  = (asm_cnt_q == LaneW'(PIX_PER_WORD - 1));

  always_comb begin
    asm_ins = asm_q;
    for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
      if (asm_cnt_q == LaneW'(i)) asm_ins[i*OUT_PIX_W +: OUT_PIX_W] = pix_q;
    end
  end

  // A full word waits in pend_q until we know whether it closes the line.
  always_comb begin
    cm_valid = 1'b0;
    cm_eol   = 1'b0;
    cm_word  = pend_q;
    if (keep && pend_valid_q) begin
      cm_valid = 1'b1;
    end else if (line_end) begin
      if (pend_valid_q) begin
        cm_valid = 1'b1;
        cm_eol   = 1'b1;
      end else if (asm_cnt_q != '0) begin
        cm_valid = 1'b1;
        cm_eol   = 1'b1;
        cm_word  = asm_q;
      end
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign fifo_push  = wr_q & ~fifo_full;
  assign fifo_pop   = ~fifo_empty & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      frame_count_q <= '0;
      skip_q        <= '0;
      decim_q       <= '0;
      asm_q         <= '0;
      asm_cnt_q     <= '0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      sop_flag_q    <= 1'b0;
      wr_q          <= 1'b0;
      wr_entry_q    <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable) state_q <= StArmed;
        end
        StArmed: begin
          if (fv_rise) begin
            state_q      <= StCapture;
            skip_q       <= skip;
            sop_flag_q   <= 1'b1;
            asm_q        <= '0;
            asm_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
          end
        end
        StCapture: begin
          if (fv_fall) begin
            frame_count_q <= frame_count_q + 16'd1;
            state_q       <= enable ? StArmed : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (lv_q) decim_q <= (decim_eff == skip_q) ? 2'd0 : decim_eff + 2'd1;

      if (cm_valid) begin
        pend_valid_q <= 1'b0;
        sop_flag_q   <= 1'b0;
      end

      if (keep) begin
        if (asm_full) begin
          pend_q       <= asm_ins;
          pend_valid_q <= 1'b1;
          asm_q        <= '0;
          asm_cnt_q    <= '0;
        end else begin
          asm_q     <= asm_ins;
          asm_cnt_q <= asm_cnt_q + LaneW'(1);
        end
      end

      if (line_end) begin
        asm_q     <= '0;
        asm_cnt_q <= '0;
      end

      wr_q       <= cm_valid;
      wr_entry_q <= {sop_flag_q, cm_eol, cm_word};

      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      // Full is judged before this cycle's pop; set wins over clear.
      if (clear_overflow)     overflow_q <= 1'b0;
      if (wr_q && fifo_full)  overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr_q[AddrW-1:0]] <= wr_entry_q;
  end

  assign head        = mem[rd_ptr_q[AddrW-1:0]];
  assign out_valid   = ~fifo_empty;
  assign out_data    = fifo_empty ? '0 : head[WORD_W-1:0];
  assign out_eol     = ~fifo_empty & head[WORD_W];
  assign out_sop     = ~fifo_empty & head[WORD_W+1];
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;
  assign busy        = capturing;

endmodule
